riscv_dmem_bridge: RTL
======================

RISCV_DMEM_BRIDGE -- requirements
Module: riscv_dmem_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES SHALL be default 255; it is the number of cycles spent in REQ+WAIT before the transaction is aborted.
REQ-002 clk  input  1  the single clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 mem_rd_en  input  1  core load request.
REQ-005 mem_wr_en  input  1  core store request.
REQ-006 mem_addr  input  32  core byte address.
REQ-007 mem_wr_data  input  32  core store data, LSB-aligned.
REQ-008 mem_width  input  4  core byte mask, LSB-aligned (0001 byte, 0011 half, 1111 word).
REQ-009 mem_rd_data  output  32  load data, shifted right by 8*mem_addr[1:0].
REQ-010 mem_stall  output  1  core freeze while a transaction is outstanding.
REQ-011 bus_req_valid / bus_req_ready  output / input  1 / 1  request handshake.
REQ-012 bus_req_we  output  1  bus write flag.
REQ-013 bus_req_addr  output  32  word-aligned bus address (addr[1:0]=0).
REQ-014 bus_req_wdata  output  32  store data shifted left by 8*addr[1:0].
REQ-015 bus_req_strb  output  4  byte mask shifted left by addr[1:0].
REQ-016 bus_rsp_valid / bus_rsp_rdata / bus_rsp_err  input  1 / 32 / 1  response beat.
REQ-017 bus_err  output  1  one-cycle pulse on error or timeout.

Function
REQ-018 The FSM SHALL have states IDLE, REQ, WAIT, DONE.
REQ-019 IDLE->REQ when mem_rd_en|mem_wr_en; capture addr, wdata, width and we in the same edge.
REQ-020 If mem_rd_en and mem_wr_en are both high, the transaction is a write and the read is dropped.
REQ-021 In REQ, bus_req_valid=1 and all request fields hold the captured values until bus_req_ready; on ready -> WAIT.
REQ-022 Writes also wait for bus_rsp_valid as their acknowledge.
REQ-023 In WAIT, bus_rsp_valid -> DONE; rdata is registered.
REQ-024 bus_rsp_valid outside WAIT SHALL be ignored.
REQ-025 DONE lasts exactly one cycle, then -> IDLE. Core request inputs are ignored in DONE; they are the retiring request.
REQ-026 mem_stall = (IDLE & (rd_en|wr_en)) | REQ | WAIT, combinational; it is 0 in DONE.
REQ-027 Minimum load latency: 3 stall cycles (IDLE, REQ with ready, WAIT with rsp).
REQ-028 mem_rd_data holds the last completed load value until the next load completes; it is 0 after error or timeout.
REQ-029 bus_rsp_err in WAIT -> DONE with bus_err=1 during DONE.
REQ-030 Lane shifts use addr[1:0] only; misalignment checking belongs to the core.

Reset
REQ-031 While reset=1: state=IDLE, bus_req_valid=0, bus_err=0, mem_rd_data=0, timeout count=0, captured registers=0.
REQ-032 Reset mid-transaction SHALL drop bus_req_valid asynchronously; the outstanding response is discarded.

Configuration
REQ-033 With RISCV_DMEM_TIMEOUT_EN defined:
- A counter increments each cycle in REQ or WAIT.
- On reaching TIMEOUT_CYCLES, go to DONE with bus_err=1 and rd_data=0, deasserting bus_req_valid.
- The counter clears on entry to IDLE.
REQ-034 Without RISCV_DMEM_TIMEOUT_EN, no counter exists and REQ/WAIT wait indefinitely.

Structure
REQ-035 Package riscv_mem_pkg SHALL hold the state enum, lane-shift functions and the default TIMEOUT_CYCLES localparam.
REQ-036 One sub-module, riscv_lane_align, SHALL be purely combinational and perform the write-data/strobe shift and the read-data shift.

Verification
REQ-037 Word load, addr 0x100, width 1111, ready immediate, rsp rdata 0xDEADBEEF one cycle later -> stall for 3 cycles, then mem_rd_data=0xDEADBEEF in DONE.
REQ-038 Byte store, addr 0x203, wdata 0xAB, width 0001 -> bus addr 0x200, wdata 0xAB000000, strb 1000, we=1.
REQ-039 Half load, addr 0x302, rsp 0x12345678, with ready held low 5 cycles -> request fields stable throughout, mem_rd_data=0x00001234.
REQ-040 rd_en=wr_en=1 -> single bus write only; rsp_err=1 -> bus_err pulses for exactly 1 cycle.
REQ-041 RISCV_DMEM_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, no response -> bus_err at cycle 8, return to IDLE. Separately, reset asserted in WAIT -> bus_req_valid=0 and mem_stall=0 immediately.

Source files
------------

// File: rtl/riscv_dmem_bridge_pkg.sv
// Shared types and lane-steering helpers for the data-memory bridge.
// Combinational helpers only; no timing or flow control lives here.
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

  function automatic logic [31:0] lane_shift_wdata(input logic [31:0] data, input logic [1:0] off);
    return data << {off, 3'b000};
  endfunction

  function automatic logic [3:0] lane_shift_strb(input logic [3:0] mask, input logic [1:0] off);
    return mask << off;
  endfunction

  function automatic logic [31:0] lane_shift_rdata(input logic [31:0] data, input logic [1:0] off);
    return data >> {off, 3'b000};
  endfunction

endpackage

// File: rtl/riscv_dmem_bridge_if.sv
// Core-side and bus-side signal bundles for the data-memory bridge.
// master issues requests, slave answers them; the bridge is core slave and bus master.
interface riscv_dmem_core_if;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic [3:0]  mem_width;
  logic [31:0] mem_rd_data;
  logic        mem_stall;

  modport master (
    output mem_rd_en, mem_wr_en, mem_addr, mem_wr_data, mem_width,
    input  mem_rd_data, mem_stall
  );

  modport slave (
    input  mem_rd_en, mem_wr_en, mem_addr, mem_wr_data, mem_width,
    output mem_rd_data, mem_stall
  );
endinterface

interface riscv_dmem_bus_if;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic        bus_req_we;
  logic [31:0] bus_req_addr;
  logic [31:0] bus_req_wdata;
  logic [3:0]  bus_req_strb;
  logic        bus_rsp_valid;
  logic [31:0] bus_rsp_rdata;
  logic        bus_rsp_err;
  logic        bus_err;

  modport master (
    output bus_req_valid, bus_req_we, bus_req_addr, bus_req_wdata, bus_req_strb, bus_err,
    input  bus_req_ready, bus_rsp_valid, bus_rsp_rdata, bus_rsp_err
  );

  modport slave (
    input  bus_req_valid, bus_req_we, bus_req_addr, bus_req_wdata, bus_req_strb, bus_err,
    output bus_req_ready, bus_rsp_valid, bus_rsp_rdata, bus_rsp_err
  );
endinterface

// File: rtl/riscv_dmem_bridge_lane_align.sv
// Byte-lane steering between the core's LSB-aligned view and the 32-bit bus lanes.
// Purely combinational, zero latency; the offset is the captured addr[1:0].
module riscv_lane_align
  import riscv_mem_pkg::*;
(
  input  logic [1:0]  offset_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  width_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  strb_o,
  output logic [31:0] rdata_o
);

  assign wdata_o = lane_shift_wdata(wdata_i, offset_i);
  assign strb_o  = lane_shift_strb(width_i, offset_i);
  assign rdata_o = lane_shift_rdata(rdata_i, offset_i);

endmodule

// File: rtl/riscv_dmem_bridge.sv
// Core load/store port to valid-ready bus bridge: IDLE->REQ->WAIT->DONE, min 3 stall cycles.
// Holds request until bus_req_ready; optional abort timer under `RISCV_DMEM_TIMEOUT_EN.
module riscv_dmem_bridge
  import riscv_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  riscv_dmem_core_if.slave core,
  riscv_dmem_bus_if.master bus
);

  state_e      state_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  width_q;
  logic        we_q;
  logic        req_vld_q;
  logic        err_q;
  logic [31:0] rd_data_q;

  logic [31:0] wdata_sh;
  logic [3:0]  strb_sh;
  logic [31:0] rdata_sh;
  logic        core_req;
  logic        busy;
  logic        timeout_hit;

  assign core_req = core.mem_rd_en | core.mem_wr_en;
  assign busy     = (state_q == ST_REQ) || (state_q == ST_WAIT);

  riscv_lane_align u_align (
    .offset_i (addr_q[1:0]),
    .wdata_i  (wdata_q),
    .width_i  (width_q),
    .rdata_i  (bus.bus_rsp_rdata),
    .wdata_o  (wdata_sh),
    .strb_o   (strb_sh),
    .rdata_o  (rdata_sh)
  );

`ifdef RISCV_DMEM_TIMEOUT_EN
  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Counts every REQ/WAIT cycle; the last DONE cycle clears it on the way back to IDLE.
  always_comb begin
    cnt_d = cnt_q;
    if (busy) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (state_q == ST_DONE) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_hit = busy && (cnt_q == CNT_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      width_q   <= '0;
      we_q      <= 1'b0;
      req_vld_q <= 1'b0;
      err_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (core_req) begin
            state_q   <= ST_REQ;
            addr_q    <= core.mem_addr;
            wdata_q   <= core.mem_wr_data;
            width_q   <= core.mem_width;
            we_q      <= core.mem_wr_en;
            req_vld_q <= 1'b1;
          end
        end
        ST_REQ: begin
          if (timeout_hit) begin
            state_q   <= ST_DONE;
            req_vld_q <= 1'b0;
            err_q     <= 1'b1;
            rd_data_q <= '0;
          end else if (bus.bus_req_ready) begin
            state_q   <= ST_WAIT;
            req_vld_q <= 1'b0;
          end
        end
        ST_WAIT: begin
          // A response landing on the timeout cycle still wins.
          if (bus.bus_rsp_valid) begin
            state_q <= ST_DONE;
            if (bus.bus_rsp_err) begin
              err_q     <= 1'b1;
              rd_data_q <= '0;
            end else if (!we_q) begin
              rd_data_q <= rdata_sh;
            end
          end else if (timeout_hit) begin
            state_q   <= ST_DONE;
            err_q     <= 1'b1;
            rd_data_q <= '0;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign core.mem_rd_data = rd_data_q;
  assign core.mem_stall   = !reset && (((state_q == ST_IDLE) && core_req) || busy);

  assign bus.bus_req_valid = req_vld_q;
  assign bus.bus_req_we    = we_q;
  assign bus.bus_req_addr  = {addr_q[31:2], 2'b00};
  assign bus.bus_req_wdata = wdata_sh;
  assign bus.bus_req_strb  = strb_sh;
  assign bus.bus_err       = err_q;

endmodule
